thunderbird_seq_ctrl: RTL

- Tail-light sequencer/arbiter for the six-lamp Thunderbird rear cluster (LA, LB, LC left; RA, RB, RC right).
- Arbitrates left, right, hazard and brake requests, and paces the lamp sequence with an internal step prescaler.
- Drives the lamp outputs directly.
- Short switch pulses are captured as pending requests, so no request is lost between steps.

---
 rtl/thunderbird_seq_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/thunderbird_seq_ctrl.sv
// Thunderbird tail-light sequencer: arbitrates turn/hazard/brake requests and
// steps the six-lamp pattern on a prescaled tick.
module thunderbird_seq_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic Clk,
    input  logic Rs,
    input  logic L,
    input  logic R,
    input  logic Haz,
    input  logic Brk,
    output logic LA,
    output logic LB,
    output logic LC,
    output logic RA,
    output logic RB,
    output logic RC,
    output logic Busy
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE, L1, L2, L3, R1, R2, R3, HZ_ON
    } base_t;

    typedef enum logic [3:0] {
        S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_HZ_ON, S_HZ_OFF
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt;
    logic            tick;
    logic            lp, rp, lp_clr, rp_clr;
    logic [5:0]      lamp_q, lamp_n;   // {LA,LB,LC,RA,RB,RC}
    logic            busy_q;
    logic [2:0]      lpat, rpat;

    assign tick = (cnt == TMAX);

    always_comb begin
        state_n = state;
        lp_clr  = 1'b0;
        rp_clr  = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (Haz || (lp && rp)) begin
                        state_n = S_HZ_ON;
                        lp_clr  = 1'b1;
                        rp_clr  = 1'b1;
                    end else if (lp) begin
                        state_n = S_L1;
                        lp_clr  = 1'b1;
                    end else if (rp) begin
                        state_n = S_R1;
                        rp_clr  = 1'b1;
                    end
                end
                S_L1:     state_n = S_L2;
                S_L2:     state_n = S_L3;
                S_L3:     state_n = S_IDLE;
                S_R1:     state_n = S_R2;
                S_R2:     state_n = S_R3;
                S_R3:     state_n = S_IDLE;
                S_HZ_ON:  state_n = S_HZ_OFF;
                S_HZ_OFF: begin
                    if (Haz) begin
                        state_n = S_HZ_ON;
                        lp_clr  = 1'b1;
                        rp_clr  = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                default:  state_n = S_IDLE;
            endcase
        end
    end

    // Lamps are decoded from the next state so they move on the same edge as State.
    always_comb begin
        lpat = 3'b000;
        rpat = 3'b000;
        case (state_n)
            S_L1:    lpat = 3'b100;
            S_L2:    lpat = 3'b110;
            S_L3:    lpat = 3'b111;
            S_R1:    rpat = 3'b100;
            S_R2:    rpat = 3'b110;
            S_R3:    rpat = 3'b111;
            S_HZ_ON: begin
                lpat = 3'b111;
                rpat = 3'b111;
            end
            default: ;
        endcase
        lamp_n = {lpat, rpat};
        if (Brk && state_n != S_HZ_ON && state_n != S_HZ_OFF) begin
            if (!(state_n inside {S_L1, S_L2, S_L3})) lamp_n[5:3] = 3'b111;
            if (!(state_n inside {S_R1, S_R2, S_R3})) lamp_n[2:0] = 3'b111;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rs) begin
            state  <= S_IDLE;
            cnt    <= '0;
            lp     <= 1'b0;
            rp     <= 1'b0;
            lamp_q <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= tick ? '0 : cnt + 1'b1;
            // A new request on the consuming cycle stays pending.
            lp     <= L | (lp & ~lp_clr);
            rp     <= R | (rp & ~rp_clr);
            lamp_q <= lamp_n;
            busy_q <= (state_n != S_IDLE);
        end
    end

    assign {LA, LB, LC, RA, RB, RC} = lamp_q;
    assign Busy = busy_q;

endmodule
